// File: rtl/ysyx_24080014_arb_pkg.sv
// Shared types for the IFU/LSU data-memory arbiter: FSM states and requester ids.
package ysyx_24080014_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/ysyx_24080014_arb_timer.sv
// Busy-cycle counter for the arbiter; expire marks the cycle in which the count
// would reach TIMEOUT_CYC while still enabled.
module ysyx_24080014_arb_timer #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/ysyx_24080014_mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter that owns the shared data-memory port and
// sequences one registered transaction at a time: IDLE -> BUSY -> RESP.
module ysyx_24080014_mem_arbiter
  import ysyx_24080014_arb_pkg::*;
#(
  parameter int unsigned MAX_CONSEC  = 4,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_valid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_ready,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_valid,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_valid,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int unsigned CONS_W = (MAX_CONSEC < 1) ? 1 : $clog2(MAX_CONSEC + 1);
  localparam logic [CONS_W-1:0] CONS_MAX = CONS_W'(MAX_CONSEC);

  arb_state_t        state_q, state_d;
  logic              req_id_q, req_id_d;
  logic [CONS_W-1:0] consec_q, consec_d;

  logic        mem_valid_d, mem_ren_d, mem_wen_d;
  logic [31:0] mem_raddr_d, mem_waddr_d, mem_wdata_d;
  logic [7:0]  mem_wmask_d;
  logic        ifu_ready_d, ifu_err_d, lsu_ready_d, lsu_err_d;
  logic [31:0] ifu_rdata_d, lsu_rdata_d;

  logic        grant_lsu, grant_ifu, timer_expire, busy_done;
  logic [31:0] resp_rdata;
  logic        resp_err;

  ysyx_24080014_arb_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ST_IDLE),
    .en     ((state_q == ST_BUSY) && !mem_ready),
    .expire (timer_expire)
  );

  // LSU has priority until it has won MAX_CONSEC grants in a row over a waiting IFU.
  assign grant_lsu  = lsu_valid && !(ifu_valid && (consec_q == CONS_MAX));
  assign grant_ifu  = ifu_valid && !grant_lsu;
  assign busy_done  = mem_ready || timer_expire;
  assign resp_rdata = (mem_ready && !mem_wen) ? mem_rdata : '0;
  assign resp_err   = !mem_ready;

  always_comb begin
    state_d     = state_q;
    req_id_d    = req_id_q;
    consec_d    = consec_q;
    mem_valid_d = mem_valid;
    mem_ren_d   = mem_ren;
    mem_wen_d   = mem_wen;
    mem_raddr_d = mem_raddr;
    mem_waddr_d = mem_waddr;
    mem_wdata_d = mem_wdata;
    mem_wmask_d = mem_wmask;
    ifu_ready_d = 1'b0;
    lsu_ready_d = 1'b0;
    ifu_rdata_d = ifu_rdata;
    ifu_err_d   = ifu_err;
    lsu_rdata_d = lsu_rdata;
    lsu_err_d   = lsu_err;
    case (state_q)
      ST_IDLE: begin
        if (grant_lsu) begin
          state_d     = ST_BUSY;
          req_id_d    = REQ_LSU;
          mem_valid_d = 1'b1;
          mem_ren_d   = !lsu_wen;
          mem_wen_d   = lsu_wen;
          mem_raddr_d = lsu_wen ? '0 : lsu_addr;
          mem_waddr_d = lsu_wen ? lsu_addr : '0;
          mem_wdata_d = lsu_wen ? lsu_wdata : '0;
          mem_wmask_d = lsu_wen ? lsu_wmask : '0;
          if (!ifu_valid) begin
            consec_d = '0;
          end else if (consec_q != CONS_MAX) begin
            consec_d = consec_q + CONS_W'(1);
          end
        end else if (grant_ifu) begin
          state_d     = ST_BUSY;
          req_id_d    = REQ_IFU;
          consec_d    = '0;
          mem_valid_d = 1'b1;
          mem_ren_d   = 1'b1;
          mem_wen_d   = 1'b0;
          mem_raddr_d = ifu_addr;
          mem_waddr_d = '0;
          mem_wdata_d = '0;
          mem_wmask_d = '0;
        end
      end
      ST_BUSY: begin
        if (busy_done) begin
          state_d     = ST_RESP;
          mem_valid_d = 1'b0;
          mem_ren_d   = 1'b0;
          mem_wen_d   = 1'b0;
          mem_raddr_d = '0;
          mem_waddr_d = '0;
          mem_wdata_d = '0;
          mem_wmask_d = '0;
          if (req_id_q == REQ_IFU) begin
            ifu_ready_d = 1'b1;
            ifu_rdata_d = resp_rdata;
            ifu_err_d   = resp_err;
          end else begin
            lsu_ready_d = 1'b1;
            lsu_rdata_d = resp_rdata;
            lsu_err_d   = resp_err;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_id_q  <= REQ_IFU;
      consec_q  <= '0;
      mem_valid <= 1'b0;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      ifu_ready <= 1'b0;
      ifu_rdata <= '0;
      ifu_err   <= 1'b0;
      lsu_ready <= 1'b0;
      lsu_rdata <= '0;
      lsu_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_id_q  <= req_id_d;
      consec_q  <= consec_d;
      mem_valid <= mem_valid_d;
      mem_ren   <= mem_ren_d;
      mem_wen   <= mem_wen_d;
      mem_raddr <= mem_raddr_d;
      mem_waddr <= mem_waddr_d;
      mem_wdata <= mem_wdata_d;
      mem_wmask <= mem_wmask_d;
      ifu_ready <= ifu_ready_d;
      ifu_rdata <= ifu_rdata_d;
      ifu_err   <= ifu_err_d;
      lsu_ready <= lsu_ready_d;
      lsu_rdata <= lsu_rdata_d;
      lsu_err   <= lsu_err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_24080014_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter with a simple latency-programmable memory.
module tb_ysyx_24080014_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_valid = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        ifu_ready;
  logic [31:0] ifu_rdata;
  logic        ifu_err;
  logic        lsu_valid = 1'b0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic [7:0]  lsu_wmask = '0;
  logic        lsu_ready;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        mem_valid, mem_ren, mem_wen;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  int unsigned vcnt = 0;
  int unsigned mem_lat = 0;
  bit          mem_never = 1'b0;
  logic [31:0] mem_data = '0;
  logic [31:0] grant_log[$];

  always #5 clk = ~clk;

  ysyx_24080014_mem_arbiter #(
    .MAX_CONSEC  (4),
    .TIMEOUT_CYC (255),
    .CNT_W       (8)
  ) dut (
    .clk (clk), .rst (rst),
    .ifu_valid (ifu_valid), .ifu_addr (ifu_addr), .ifu_ready (ifu_ready),
    .ifu_rdata (ifu_rdata), .ifu_err (ifu_err),
    .lsu_valid (lsu_valid), .lsu_wen (lsu_wen), .lsu_addr (lsu_addr),
    .lsu_wdata (lsu_wdata), .lsu_wmask (lsu_wmask), .lsu_ready (lsu_ready),
    .lsu_rdata (lsu_rdata), .lsu_err (lsu_err),
    .mem_valid (mem_valid), .mem_ren (mem_ren), .mem_wen (mem_wen),
    .mem_raddr (mem_raddr), .mem_waddr (mem_waddr), .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask), .mem_rdata (mem_rdata), .mem_ready (mem_ready)
  );

  // Memory model: answers mem_lat cycles after the first mem_valid cycle; logs each new grant address.
  always @(negedge clk) begin
    if (mem_valid) begin
      vcnt = vcnt + 1;
      if (vcnt == 1) grant_log.push_back(mem_wen ? mem_waddr : mem_raddr);
    end else begin
      vcnt = 0;
    end
    mem_rdata = mem_data;
    mem_ready = mem_valid && !mem_never && (vcnt > mem_lat);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_valid, mem_ren, mem_wen, ifu_ready, ifu_err, lsu_ready, lsu_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {mem_valid, mem_ren, mem_wen, ifu_ready, ifu_err, lsu_ready, lsu_err});
    end
    checks++;
    if ({mem_raddr, mem_waddr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0",
               {mem_raddr, mem_waddr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ifu_read();
    int lat = 0;
    bit got = 0;
    logic [31:0] a_seen = '0;
    logic [1:0]  en_seen = '0;
    mem_lat = 0; mem_never = 0; mem_data = 32'h0000_0413;
    ifu_valid = 1'b1; ifu_addr = 32'h8000_0000;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin a_seen = mem_raddr; en_seen = {mem_valid, mem_ren}; end
      if (ifu_ready) got = 1;
    end
    ifu_valid = 1'b0;
    checks++;
    if (en_seen !== 2'b11 || a_seen !== 32'h8000_0000) begin
      errors++;
      $display("FAIL ifu_issue: valid/ren=%b raddr=%h expected 11 80000000", en_seen, a_seen);
    end
    checks++;
    if (!got || lat != 2) begin
      errors++;
      $display("FAIL ifu_latency: got=%0d lat=%0d expected ready at 2", got, lat);
    end
    checks++;
    if (ifu_rdata !== 32'h0000_0413 || ifu_err !== 1'b0 || lsu_ready !== 1'b0) begin
      errors++;
      $display("FAIL ifu_resp: rdata=%h err=%b lsu_ready=%b expected 00000413 0 0",
               ifu_rdata, ifu_err, lsu_ready);
    end
    @(negedge clk);
    checks++;
    if (ifu_ready !== 1'b0 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL ifu_single_pulse: ready=%b mem_valid=%b expected 0 0", ifu_ready, mem_valid);
    end
  endtask

  task automatic test_simultaneous();
    mem_lat = 0; mem_never = 0; mem_data = 32'hCAFE_F00D;
    ifu_valid = 1'b1; ifu_addr = 32'h8000_0004;
    lsu_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0100;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
    @(negedge clk);
    checks++;
    if ({mem_valid, mem_wen, mem_ren} !== 3'b110 || mem_waddr !== 32'h8000_0100 ||
        mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 8'h0F) begin
      errors++;
      $display("FAIL store_issue: v/w/r=%b waddr=%h wdata=%h wmask=%h expected 110 80000100 deadbeef 0f",
               {mem_valid, mem_wen, mem_ren}, mem_waddr, mem_wdata, mem_wmask);
    end
    @(negedge clk);
    checks++;
    if (lsu_ready !== 1'b1 || lsu_rdata !== 32'h0 || lsu_err !== 1'b0 || ifu_ready !== 1'b0) begin
      errors++;
      $display("FAIL store_resp: ready=%b rdata=%h err=%b ifu_ready=%b expected 1 00000000 0 0",
               lsu_ready, lsu_rdata, lsu_err, ifu_ready);
    end
    lsu_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_valid, mem_ren, mem_wen} !== 3'b110 || mem_raddr !== 32'h8000_0004) begin
      errors++;
      $display("FAIL ifu_after_lsu: v/r/w=%b raddr=%h expected 110 80000004",
               {mem_valid, mem_ren, mem_wen}, mem_raddr);
    end
    @(negedge clk);
    checks++;
    if (ifu_ready !== 1'b1 || ifu_rdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL ifu_after_lsu_resp: ready=%b rdata=%h expected 1 cafef00d", ifu_ready, ifu_rdata);
    end
    ifu_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fairness();
    logic [31:0] exp_seq[6];
    exp_seq = '{32'h8000_2000, 32'h8000_2000, 32'h8000_2000, 32'h8000_2000,
                32'h8000_1000, 32'h8000_2000};
    mem_lat = 0; mem_never = 0; mem_data = 32'h1;
    grant_log.delete();
    ifu_valid = 1'b1; ifu_addr = 32'h8000_1000;
    lsu_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_2000;
    for (int i = 0; i < 40 && grant_log.size() < 6; i++) @(negedge clk);
    ifu_valid = 1'b0; lsu_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (grant_log.size() < 6) begin
      errors++;
      $display("FAIL fair_count: got %0d grants expected at least 6", grant_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (grant_log[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL fair_grant%0d: got %h expected %h", i, grant_log[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int vc = 0;
    bit got = 0;
    mem_never = 1; mem_data = 32'h5555_AAAA;
    lsu_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_3000;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (mem_valid) vc++;
      if (lsu_ready) got = 1;
    end
    lsu_valid = 1'b0;
    checks++;
    if (!got || vc != 255) begin
      errors++;
      $display("FAIL timeout_len: ready=%0d busy=%0d expected 1 255", got, vc);
    end
    checks++;
    if (lsu_err !== 1'b1 || lsu_rdata !== 32'h0 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_resp: err=%b rdata=%h mem_valid=%b expected 1 00000000 0",
               lsu_err, lsu_rdata, mem_valid);
    end
    mem_never = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout_edge();
    int vc = 0;
    bit got = 0;
    mem_never = 0; mem_lat = 254; mem_data = 32'h1234_5678;
    ifu_valid = 1'b1; ifu_addr = 32'h8000_0008;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (mem_valid) vc++;
      if (ifu_ready) got = 1;
    end
    ifu_valid = 1'b0;
    checks++;
    if (!got || vc != 255) begin
      errors++;
      $display("FAIL edge_len: ready=%0d busy=%0d expected 1 255", got, vc);
    end
    checks++;
    if (ifu_err !== 1'b0 || ifu_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL edge_resp: err=%b rdata=%h expected 0 12345678", ifu_err, ifu_rdata);
    end
    mem_lat = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit pulse = 0;
    bit mv = 0;
    mem_never = 1;
    lsu_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_4000;
    repeat (4) @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1 || mem_raddr !== 32'h8000_4000) begin
      errors++;
      $display("FAIL rst_pre: mem_valid=%b raddr=%h expected 1 80004000", mem_valid, mem_raddr);
    end
    rst = 1'b1; lsu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_valid, mem_ren, mem_wen, ifu_ready, ifu_err, lsu_ready, lsu_err} !== 7'b0 ||
        {mem_raddr, mem_waddr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata} !== '0) begin
      errors++;
      $display("FAIL rst_mid: ctrl=%b raddr=%h rdata=%h expected all 0",
               {mem_valid, mem_ren, mem_wen, ifu_ready, ifu_err, lsu_ready, lsu_err},
               mem_raddr, lsu_rdata);
    end
    rst = 1'b0; mem_never = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (lsu_ready) pulse = 1;
      if (mem_valid) mv = 1;
    end
    checks++;
    if (pulse || mv) begin
      errors++;
      $display("FAIL rst_discard: lsu_ready_seen=%0d mem_valid_seen=%0d expected 0 0", pulse, mv);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ifu_read();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
